// File: rtl/hash_job_scheduler.sv
// Job dispatcher for a pool of SHA-256 hash cores: a small FIFO of address pairs feeds
// idle cores round-robin, tracks per-core busy state, completions and watchdog errors.
module hash_job_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int QDEPTH    = 2,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [15:0]            job_message_addr,
  input  logic [15:0]            job_output_addr,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [NUM_CORES*16-1:0] core_message_addr,
  output logic [NUM_CORES*16-1:0] core_output_addr,
  input  logic [NUM_CORES-1:0]   core_done,
  output logic [NUM_CORES-1:0]   core_busy,
  output logic                   all_idle,
  output logic [15:0]            jobs_completed,
  output logic [NUM_CORES-1:0]   timeout_err
);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [11:0] WD_LIMIT = 12'(TIMEOUT - 1);

  logic [31:0]          q_mem [0:QDEPTH-1];
  logic [QW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [QW:0]          count_reg;
  logic [CW-1:0]        last_grant_reg;
  logic [15:0]          jobs_completed_reg;
  logic [31:0]          head;
  logic                 push, dispatch, grant_valid;
  logic [CW-1:0]        grant_idx;
  logic [NUM_CORES-1:0] eligible, completion, grant_onehot;
  logic [15:0]          done_cnt;

  assign job_ready      = (count_reg != QW'(0) + (QW+1)'(QDEPTH)) ? 1'b1 : 1'b0;
  assign push           = job_valid && job_ready;
  assign head           = q_mem[rd_ptr_reg];
  assign all_idle       = (count_reg == '0) && !(|core_busy);
  assign jobs_completed = jobs_completed_reg;

  // Round-robin search starting just after the last granted core; busy/err are
  // registered, so a core freed this cycle only becomes eligible next cycle.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
    dispatch     = grant_valid && (count_reg != '0);
    grant_onehot = '0;
    if (dispatch) grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) done_cnt = done_cnt + 16'(completion[i]);
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_reg] <= {job_message_addr, job_output_addr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      last_grant_reg     <= CW'(NUM_CORES - 1);
      jobs_completed_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (dispatch) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        last_grant_reg <= grant_idx;
      end
      case ({push, dispatch})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      jobs_completed_reg <= jobs_completed_reg + done_cnt;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic        busy_reg, err_reg, start_reg, done_prev_reg;
      logic [11:0] wd_reg;
      logic [15:0] msg_reg, out_reg;

      assign eligible[gi]   = !busy_reg && !err_reg;
      // Only a 0->1 transition of done while busy credits the job.
      assign completion[gi] = core_done[gi] && !done_prev_reg && busy_reg;
      assign core_busy[gi]   = busy_reg;
      assign timeout_err[gi] = err_reg;
      assign core_start[gi]  = start_reg;
      assign core_message_addr[16*gi +: 16] = msg_reg;
      assign core_output_addr[16*gi +: 16]  = out_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          busy_reg      <= 1'b0;
          err_reg       <= 1'b0;
          start_reg     <= 1'b0;
          done_prev_reg <= 1'b0;
          wd_reg        <= '0;
          msg_reg       <= '0;
          out_reg       <= '0;
        end else begin
          done_prev_reg <= core_done[gi];
          start_reg     <= grant_onehot[gi];
          if (grant_onehot[gi]) begin
            msg_reg  <= head[31:16];
            out_reg  <= head[15:0];
            busy_reg <= 1'b1;
            wd_reg   <= '0;
          end else if (completion[gi]) begin
            busy_reg <= 1'b0;
          end else if (busy_reg && wd_reg == WD_LIMIT) begin
            err_reg  <= 1'b1;
            busy_reg <= 1'b0;
          end else if (busy_reg) begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_hash_job_scheduler.sv
// Directed bench for hash_job_scheduler: 4 cores, 2-deep queue, 20-cycle watchdog.
module tb_hash_job_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [15:0] job_message_addr = '0;
  logic [15:0] job_output_addr = '0;
  logic [3:0]  core_start;
  logic [63:0] core_message_addr;
  logic [63:0] core_output_addr;
  logic [3:0]  core_done = '0;
  logic [3:0]  core_busy;
  logic        all_idle;
  logic [15:0] jobs_completed;
  logic [3:0]  timeout_err;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [3:0]  start_seen;
  logic [31:0] grant_log;
  int          grant_cnt;

  hash_job_scheduler #(.NUM_CORES(4), .QDEPTH(2), .TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_message_addr(job_message_addr), .job_output_addr(job_output_addr),
    .core_start(core_start), .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr), .core_done(core_done),
    .core_busy(core_busy), .all_idle(all_idle),
    .jobs_completed(jobs_completed), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge, sample 1ns later, and log which core started.
  task automatic tick();
    @(posedge clk);
    #1;
    start_seen = start_seen | core_start;
    for (int i = 0; i < 4; i++) begin
      if (core_start[i] && grant_cnt < 8) begin
        grant_log[4*grant_cnt +: 4] = 4'(i);
        grant_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    core_done = '0;
    job_valid = 1'b0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    grant_log = '0;
    grant_cnt = 0;
  endtask

  // Offer n jobs back-to-back (message = base+j, output = base+0x100+j).
  task automatic push_burst(input int n, input logic [15:0] base);
    int   sent;
    int   cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    job_valid        = 1'b1;
    job_message_addr = base;
    job_output_addr  = base + 16'h0100;
    while (sent < n && cyc < 40) begin
      acc = job_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        job_message_addr = base + 16'(sent);
        job_output_addr  = base + 16'h0100 + 16'(sent);
      end
    end
    job_valid = 1'b0;
    check("burst_accepted", 64'(sent), 64'(n));
  endtask

  initial begin
    start_seen = '0;
    grant_log  = '0;
    grant_cnt  = 0;

    // Reset values
    tick();
    tick();
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_all_idle", 64'(all_idle), 64'd1);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_busy", 64'(core_busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_jobs_completed", 64'(jobs_completed), 64'd0);
    check("rst_msg_addr", core_message_addr, 64'd0);
    check("rst_out_addr", core_output_addr, 64'd0);
    reset_n = 1'b1;
    start_seen = '0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_start", 64'(start_seen), 64'd0);

    // Single job: accepted at edge k, start visible after edge k+1
    job_valid = 1'b1; job_message_addr = 16'h0000; job_output_addr = 16'h00B0;
    tick();
    job_valid = 1'b0;
    check("single_start_not_yet", 64'(core_start), 64'd0);
    check("single_not_idle", 64'(all_idle), 64'd0);
    tick();
    check("single_start", 64'(core_start), 64'h1);
    check("single_msg0", 64'(core_message_addr[15:0]), 64'h0000);
    check("single_out0", 64'(core_output_addr[15:0]), 64'h00B0);
    check("single_busy", 64'(core_busy), 64'h1);
    tick();
    check("single_start_pulse", 64'(core_start), 64'h0);
    check("single_addr_hold", 64'(core_output_addr[15:0]), 64'h00B0);
    core_done[0] = 1'b1;
    tick();
    check("single_done_busy", 64'(core_busy), 64'h0);
    check("single_done_count", 64'(jobs_completed), 64'd1);
    check("single_done_idle", 64'(all_idle), 64'd1);
    core_done[0] = 1'b0;
    tick();

    // Round-robin fill: 6 jobs, 4 cores, 2-deep queue
    do_reset();
    push_burst(6, 16'h1000);
    tick();
    check("rr_grant_count", 64'(grant_cnt), 64'd4);
    check("rr_grant_order", 64'(grant_log[15:0]), 64'h3210);
    check("rr_busy_all", 64'(core_busy), 64'hF);
    check("rr_queue_full", 64'(job_ready), 64'd0);
    check("rr_msg1", 64'(core_message_addr[31:16]), 64'h1001);
    check("rr_out3", 64'(core_output_addr[63:48]), 64'h1103);
    core_done[2] = 1'b1;
    tick();
    check("rr_freed_not_same_cycle", 64'(core_start), 64'h0);
    check("rr_busy_after_done", 64'(core_busy), 64'hB);
    tick();
    check("rr_redispatch_core2", 64'(core_start), 64'h4);
    check("rr_msg2_new", 64'(core_message_addr[47:32]), 64'h1004);
    check("rr_ready_again", 64'(job_ready), 64'd1);
    core_done[2] = 1'b0;

    // Two completions in the same cycle a job is pushed
    do_reset();
    push_burst(4, 16'h2000);
    tick();
    check("sim_busy_all", 64'(core_busy), 64'hF);
    core_done = 4'b1010;
    job_valid = 1'b1; job_message_addr = 16'h2100; job_output_addr = 16'h2200;
    tick();
    job_valid = 1'b0;
    check("sim_jobs_plus2", 64'(jobs_completed), 64'd2);
    check("sim_no_start_freed_cycle", 64'(core_start), 64'h0);
    check("sim_busy_cleared", 64'(core_busy), 64'h5);
    tick();
    check("sim_start_core1", 64'(core_start), 64'h2);
    check("sim_msg1", 64'(core_message_addr[31:16]), 64'h2100);
    core_done = '0;

    // Watchdog on core 0
    do_reset();
    push_burst(1, 16'h3000);
    tick();
    check("wd_start", 64'(core_start), 64'h1);
    for (int i = 0; i < 19; i++) tick();
    check("wd_before_err", 64'(timeout_err), 64'h0);
    check("wd_before_busy", 64'(core_busy), 64'h1);
    tick();
    check("wd_err", 64'(timeout_err), 64'h1);
    check("wd_busy_clear", 64'(core_busy), 64'h0);
    check("wd_no_credit", 64'(jobs_completed), 64'd0);
    push_burst(3, 16'h3100);
    tick();
    check("wd_others_busy", 64'(core_busy), 64'hE);
    core_done = 4'b1110;
    tick();
    check("wd_jobs3", 64'(jobs_completed), 64'd3);
    core_done = '0;
    tick();
    push_burst(1, 16'h3200);
    tick();
    check("wd_skip_core0", 64'(core_start), 64'h2);
    check("wd_err_sticky", 64'(timeout_err), 64'h1);

    // Sticky done across two jobs, then asynchronous reset mid-job
    do_reset();
    push_burst(4, 16'h4000);
    tick();
    core_done[1] = 1'b1;
    tick();
    check("sticky_first_credit", 64'(jobs_completed), 64'd1);
    push_burst(1, 16'h4100);
    tick();
    check("sticky_start_core1", 64'(core_start), 64'h2);
    tick();
    tick();
    check("sticky_still_busy", 64'(core_busy), 64'hF);
    check("sticky_no_recredit", 64'(jobs_completed), 64'd1);
    core_done[3] = 1'b1;
    tick();
    check("sticky_three_busy", 64'(core_busy), 64'h7);
    check("sticky_jobs2", 64'(jobs_completed), 64'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_busy", 64'(core_busy), 64'h0);
    check("async_jobs", 64'(jobs_completed), 64'd0);
    check("async_msg", core_message_addr, 64'd0);
    check("async_ready", 64'(job_ready), 64'd1);
    check("async_idle", 64'(all_idle), 64'd1);
    core_done = '0;
    tick();
    reset_n = 1'b1;
    tick();
    push_burst(1, 16'h5000);
    tick();
    check("post_reset_core0", 64'(core_start), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
